divider_arbiter: RTL and testbench

Shares one `divider` instance between N_REQ requesters.
- Arbitrates round-robin, latches the winner's operands and drives the divider's start/operand/clear inputs.
- Captures the result and flags, and returns them tagged with the requester id.
- Sits between the requester ports and the single divider datapath; it owns the divider's `start` and `sclr`.

---
 rtl/div_arb_pkg.sv | 18 +
 rtl/divider_arbiter_rr.sv | 30 +++
 rtl/divider_arbiter.sv | 120 ++++++++++++
 tb/tb_divider_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider_arbiter slice.
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned DEF_WIDTH = 10;

    // Requester-id width; never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/divider_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod N_REQ.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   id,
    output logic             any
);

    int unsigned idx;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = (32'(ptr) + off) % N_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one divider between N_REQ requesters with round-robin grants.
// Optional WAIT-state timeout abort when DIV_ARB_TIMEOUT_EN is defined.
module divider_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     sclr,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_flat,
    input  logic [N_REQ*WIDTH-1:0]   b_flat,
    output logic [N_REQ-1:0]         ack,
    output logic                     rsp_valid,
    output logic [id_w(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]         rsp_q,
    output logic                     rsp_dvz,
    output logic                     rsp_ovf,
    output logic                     rsp_to,
    output logic                     div_start,
    output logic                     div_sclr,
    output logic [WIDTH-1:0]         div_a,
    output logic [WIDTH-1:0]         div_b,
    input  logic                     div_busy,
    input  logic                     div_valid,
    input  logic [WIDTH-1:0]         div_q,
    input  logic                     div_dvz,
    input  logic                     div_ovf
);

    localparam int unsigned IDW = id_w(N_REQ);

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr, id_r, pick_id;
    logic [N_REQ-1:0] pick_grant;
    logic             pick_any, grant_go, capture, abort_pulse, wait_first;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    assign grant_go  = (state == IDLE) && pick_any && !div_busy && !sclr;
    assign ack       = grant_go ? pick_grant : '0;
    // div_valid is a level that may still reflect the previous op on the first WAIT cycle
    assign capture   = (state == WAIT) && !wait_first && div_valid && !div_busy;
    assign div_start = (state == ISSUE) && !sclr;
    assign rsp_valid = (state == RESP) && !sclr;
    assign div_sclr  = sclr | abort_pulse;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    assign abort_pulse = (state == WAIT) && !capture && !sclr && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (sclr || state != WAIT) wait_cnt <= '0;
        else                       wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign abort_pulse = (TIMEOUT == 0) && 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_go) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (capture || abort_pulse) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state      <= IDLE;
            ptr        <= '0;
            id_r       <= '0;
            wait_first <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            rsp_id     <= '0;
            rsp_q      <= '0;
            rsp_dvz    <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_to     <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_first <= (state == ISSUE);
            if (grant_go) begin
                id_r  <= pick_id;
                div_a <= a_flat[pick_id*WIDTH +: WIDTH];
                div_b <= b_flat[pick_id*WIDTH +: WIDTH];
            end
            if (capture) begin
                rsp_id  <= id_r;
                rsp_q   <= div_q;
                rsp_dvz <= div_dvz;
                rsp_ovf <= div_ovf;
                rsp_to  <= 1'b0;
            end else if (abort_pulse) begin
                rsp_id  <= id_r;
                rsp_q   <= '0;
                rsp_dvz <= 1'b0;
                rsp_ovf <= 1'b0;
                rsp_to  <= 1'b1;
            end
            if (state == RESP)
                ptr <= (id_r == IDW'(N_REQ - 1)) ? '0 : id_r + 1'b1;
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural divider stub.
// Timeout step is compiled only when DIV_ARB_TIMEOUT_EN is defined.
module tb_divider_arbiter;
    import div_arb_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 10;
    localparam int unsigned IDW = id_w(N);

    logic           clk = 1'b0;
    logic           sclr;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat, b_flat;
    logic [N-1:0]   ack;
    logic           rsp_valid, rsp_dvz, rsp_ovf, rsp_to;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_q, div_a, div_b, div_q;
    logic           div_start, div_sclr, div_busy, div_valid, div_dvz, div_ovf;

    int checks = 0;
    int errors = 0;

    int stub_cnt;
    int lat  = 4;
    bit hang = 1'b0;

    int ack_cnt, start_cnt, rsp_cnt, dsclr_cnt, overlap, cyc, start_cyc, rsp_cyc;
    int ack_order[$];
    int rsp_ids[$];
    int rsp_qs[$];
    logic [W-1:0]   last_q, last_a;
    logic [IDW-1:0] last_id;
    logic           last_dvz, last_ovf, last_to;

    always #5 clk = ~clk;

    divider_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(20)) dut (
        .clk       (clk),
        .sclr      (sclr),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_dvz   (rsp_dvz),
        .rsp_ovf   (rsp_ovf),
        .rsp_to    (rsp_to),
        .div_start (div_start),
        .div_sclr  (div_sclr),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_busy  (div_busy),
        .div_valid (div_valid),
        .div_q     (div_q),
        .div_dvz   (div_dvz),
        .div_ovf   (div_ovf)
    );

    // Divider stub: valid (level) appears lat cycles after start; hang keeps it busy forever.
    always_ff @(posedge clk) begin
        if (div_sclr) begin
            div_busy  <= 1'b0;
            div_valid <= 1'b0;
            div_q     <= '0;
            div_dvz   <= 1'b0;
            div_ovf   <= 1'b0;
            stub_cnt  <= 0;
        end else if (div_start) begin
            div_busy  <= 1'b1;
            div_valid <= 1'b0;
            stub_cnt  <= lat;
            div_dvz   <= (div_b == 0);
            div_q     <= (div_b == 0) ? '1 : div_a / div_b;
            div_ovf   <= 1'b0;
        end else if (div_busy && !hang) begin
            if (stub_cnt <= 1) begin
                div_busy  <= 1'b0;
                div_valid <= 1'b1;
            end
            stub_cnt <= stub_cnt - 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (|ack) begin
            ack_cnt++;
            for (int i = 0; i < N; i++) if (ack[i]) ack_order.push_back(i);
        end
        if (div_start) begin
            start_cnt++;
            start_cyc = cyc;
            if (div_busy) overlap++;
        end
        if (div_sclr && !sclr) dsclr_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc  = cyc;
            rsp_ids.push_back(int'(rsp_id));
            rsp_qs.push_back(int'(rsp_q));
            last_id  = rsp_id;
            last_q   = rsp_q;
            last_dvz = rsp_dvz;
            last_ovf = rsp_ovf;
            last_to  = rsp_to;
            last_a   = div_a;
        end
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ack_cnt = 0; start_cnt = 0; rsp_cnt = 0; dsclr_cnt = 0; overlap = 0;
        ack_order.delete();
        rsp_ids.delete();
        rsp_qs.delete();
    endtask

    task automatic set_op(input int id, input int unsigned a, input int unsigned b);
        a_flat[id*W +: W] = W'(a);
        b_flat[id*W +: W] = W'(b);
    endtask

    // Steps cycles until n responses were seen; drops each acked req unless keep is set.
    task automatic run_until(input int n, input bit keep, input int budget);
        logic [N-1:0] seen;
        int c;
        c = 0;
        while (rsp_cnt < n && c < budget) begin
            @(negedge clk);
            #1;
            seen = ack;
            @(posedge clk);
            #1;
            if (!keep) req = req & ~seen;
            c++;
        end
        chk("run_budget", int'(rsp_cnt >= n), 1);
    endtask

    initial begin
        sclr = 1'b1; req = '0; a_flat = '0; b_flat = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_sclr", div_sclr, 1);
        chk("rst_div_a", div_a, 0);
        chk("rst_div_b", div_b, 0);
        chk("rst_rsp_q", rsp_q, 0);
        chk("rst_rsp_to", rsp_to, 0);
        tick();
        sclr = 1'b0;
        tick();
        clear_mon();

        // single op 116/8
        set_op(0, 116, 8);
        req[0] = 1'b1;
        run_until(1, 1'b0, 40);
        chk("single_ack_cnt", ack_cnt, 1);
        chk("single_start_cnt", start_cnt, 1);
        chk("single_rsp_cnt", rsp_cnt, 1);
        chk("single_id", last_id, 0);
        chk("single_q", last_q, 14);
        chk("single_dvz", last_dvz, 0);
        chk("single_ovf", last_ovf, 0);
        chk("single_to", last_to, 0);
        chk("single_div_a_stable", last_a, 116);
        chk("single_latency", rsp_cyc - start_cyc, 6);
        chk("single_rsp_valid_low", rsp_valid, 0);
        chk("single_q_hold", rsp_q, 14);

        // divide by zero 37/0
        clear_mon();
        set_op(2, 37, 0);
        req[2] = 1'b1;
        run_until(1, 1'b0, 40);
        chk("dvz_ack_cnt", ack_cnt, 1);
        chk("dvz_id", last_id, 2);
        chk("dvz_flag", last_dvz, 1);

        // contention from ptr=0
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        clear_mon();
        set_op(1, 100, 10);
        set_op(3, 50, 5);
        req = 4'b1010;
        run_until(2, 1'b0, 80);
        chk("cont_n", rsp_ids.size(), 2);
        chk("cont_id0", rsp_ids[0], 1);
        chk("cont_q0", rsp_qs[0], 10);
        chk("cont_id1", rsp_ids[1], 3);
        chk("cont_q1", rsp_qs[1], 10);
        chk("cont_starts", start_cnt, 2);
        chk("cont_overlap", overlap, 0);

        // fairness with all four held
        clear_mon();
        set_op(0, 10, 1); set_op(1, 20, 2); set_op(2, 30, 3); set_op(3, 40, 4);
        req = 4'b1111;
        run_until(8, 1'b1, 200);
        req = '0;
        chk("fair_ack_cnt", ack_cnt, 8);
        chk("fair_order_n", ack_order.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("fair_order_%0d", i), ack_order[i], i % 4);
        tick();
        tick();

        // reset mid-op: ptr moved to 2, then aborted op must not advance or respond
        clear_mon();
        set_op(1, 9, 3);
        req[1] = 1'b1;
        run_until(1, 1'b0, 40);
        chk("pre_rst_q", last_q, 3);
        lat = 10;
        clear_mon();
        set_op(2, 20, 4);
        req[2] = 1'b1;
        for (int c = 0; c < 20 && start_cnt == 0; c++) tick();
        chk("midop_started", start_cnt, 1);
        req = '0;
        tick();
        tick();
        @(negedge clk);
        sclr = 1'b1;
        #1;
        chk("midop_div_sclr", div_sclr, 1);
        @(posedge clk);
        #1;
        sclr = 1'b0;
        repeat (15) tick();
        chk("midop_no_rsp", rsp_cnt, 0);
        lat = 4;
        clear_mon();
        set_op(0, 60, 6);
        set_op(3, 8, 2);
        req = 4'b1001;
        run_until(1, 1'b0, 40);
        req = '0;
        chk("post_rst_id", last_id, 0);
        chk("post_rst_q", last_q, 10);
        tick();
        tick();

`ifdef DIV_ARB_TIMEOUT_EN
        // stuck divider: abort after 20 WAIT cycles
        clear_mon();
        hang = 1'b1;
        set_op(1, 5, 1);
        req[1] = 1'b1;
        run_until(1, 1'b0, 80);
        hang = 1'b0;
        chk("to_flag", last_to, 1);
        chk("to_q", last_q, 0);
        chk("to_id", last_id, 1);
        chk("to_dsclr_pulses", dsclr_cnt, 1);
        chk("to_latency", rsp_cyc - start_cyc, 21);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
